// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end definitions: fetch FSM encoding, NOP, reset PC and the
// PCAsrc/PCBsrc select meanings used by both branch condition logic and fetch.
package rv32i_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        TRAP  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP          = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    localparam logic PCA_IMM  = 1'b0;
    localparam logic PCA_FOUR = 1'b1;
    localparam logic PCB_PC   = 1'b0;
    localparam logic PCB_RS1  = 1'b1;

    function automatic logic [31:0] plus4(input logic [31:0] a);
        return a + 32'd4;
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC adder: base (pc or rs1) plus offset (imm or 4), with the
// JALR bit-0 clear and an instruction-address-misaligned flag.
module next_pc_calc
    import rv32i_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] rs1,
    input  logic [31:0] imm,
    input  logic        PCAsrc,
    input  logic        PCBsrc,
    output logic [31:0] target,
    output logic        misaligned
);

    logic [31:0] base;
    logic [31:0] off;
    logic [31:0] sum;

    always_comb begin
        base = (PCBsrc == PCB_RS1)  ? rs1   : pc;
        off  = (PCAsrc == PCA_FOUR) ? 32'd4 : imm;
        sum  = base + off;
        // JALR targets drop bit 0 before the alignment check
        target     = {sum[31:1], (PCBsrc == PCB_RS1) ? 1'b0 : sum[0]};
        misaligned = |target[1:0];
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Non-overlapped PC / instruction-fetch sequencer: fetches one word over a
// req/ack port, issues it, and waits for the branch outcome before refetching.
module pc_fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCAsrc,
    input  logic        PCBsrc,
    input  logic [31:0] imm,
    input  logic [31:0] rs1,
    input  logic        br_valid,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        misalign
);

    fetch_state_t state, nstate;
    logic [31:0]  pc_q;
    logic [31:0]  instr_q;
    logic [31:0]  target;
    logic         tgt_misaligned;
    logic         resolve;

    next_pc_calc u_next_pc (
        .pc         (pc_q),
        .rs1        (rs1),
        .imm        (imm),
        .PCAsrc     (PCAsrc),
        .PCBsrc     (PCBsrc),
        .target     (target),
        .misaligned (tgt_misaligned)
    );

    assign resolve = (state == ISSUE) && br_valid && !stall;

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    nstate = FETCH;
            FETCH:   if (imem_ack) nstate = ISSUE;
            ISSUE:   if (resolve) nstate = tgt_misaligned ? TRAP : FETCH;
            TRAP:    nstate = TRAP;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP;
        end else begin
            state <= nstate;
            if (state == FETCH && imem_ack)
                instr_q <= imem_rdata;
            // a trapping target leaves the PC pointing at the faulting instruction
            if (resolve && !tgt_misaligned)
                pc_q <= target;
        end
    end

    assign imem_req    = (state == FETCH);
    assign imem_addr   = pc_q;
    assign pc_out      = pc_q;
    assign pc_plus4    = plus4(pc_q);
    assign instr       = instr_q;
    assign instr_valid = (state == ISSUE);
    assign misalign    = (state == TRAP);

endmodule
